irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources (1..8).
REQ-002 SHALL have parameter EDGE_MASK, default 8'h00: bit i=1 makes source i edge-triggered (rising); 0 makes it level-triggered.
REQ-003 SHALL have port input_clk  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port select  in  1  CPU bus select for this block.
REQ-006 SHALL have port addr  in  2  word address (mem_addr[3:2]).
REQ-007 SHALL have port we  in  4  CPU byte write strobes; only we[0] is used.
REQ-008 SHALL have port rd  in  1  CPU read strobe.
REQ-009 SHALL have port wdata  in  32  CPU write data.
REQ-010 SHALL have port rdata  out  32  CPU read data, combinational from addr.
REQ-011 SHALL have port src  in  NSRC  interrupt source lines (timer, uart, econet rx, econet timer, sdcard).
REQ-012 SHALL have port irq  out  1  registered interrupt request to the CPU.

Function
REQ-013 SHALL present a register map: addr 0 PENDING; 1 ENABLE; 2 VECTOR; 3 CTRL.
REQ-014 PENDING read SHALL return {24'b0, pending}; write with we[0] SHALL clear every edge-latched bit where wdata[i]=1 (W1C); level bits ignore writes.
REQ-015 ENABLE SHALL be R/W, 8 bits in wdata[7:0], write on select & we[0].
REQ-016 VECTOR SHALL be read-only: bit31 = any enabled pending; bits[2:0] = lowest-numbered i with pending[i] & enable[i]; 0 when none.
REQ-017 CTRL bit0 SHALL be global enable (R/W); bits[31:1] read 0.
REQ-018 Level source: pending[i] SHALL equal the sampled source level src_s[i]; no latching.
REQ-019 Edge source: pending[i] SHALL be set at the clock edge where src_s[i]=1 and its previous sample src_d[i]=0, and held until cleared by W1C.
REQ-020 Simultaneous new edge and W1C on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-021 irq SHALL be registered: irq <= ctrl[0] & |(pending & enable); one cycle after pending/enable/ctrl change.
REQ-022 Bits at or above NSRC SHALL read 0 in PENDING and ENABLE and never contribute to irq.
REQ-023 Writes with select=0 or we[0]=0 SHALL have no effect; rd has no side effects.
REQ-024 rdata SHALL be 32'h0 when select=0.

Reset
REQ-025 On reset: pending=0, enable=0, ctrl=0, src_d=0, synchronizer flops=0, irq=0.
REQ-026 Reset asserted mid-operation SHALL clear all state immediately (asynchronous); first edge detection after release uses src_d=0, so a source already high at release counts as a rising edge.

Configuration
REQ-027 Macro IRQ_CTL_SYNC_EN defined: each src SHALL pass through a 2-flop synchronizer before src_s, adding 2 cycles latency (for econet_clk-domain sources).
REQ-028 Macro IRQ_CTL_SYNC_EN undefined: src_s SHALL equal src directly; src assumed synchronous to input_clk.

Verification (NSRC=8, EDGE_MASK=8'h0F, macro undefined unless stated)
REQ-029 Reset release, no stimulus -> rdata=0 at all four addresses, irq=0.
REQ-030 ENABLE=8'h01, CTRL=1, pulse src[0] one cycle -> PENDING=8'h01 held, irq=1 one cycle after pending set; VECTOR=32'h8000_0000; write PENDING 8'h01 -> pending 0, irq=0 next cycle.
REQ-031 ENABLE=8'h30, CTRL=1, hold src[4] and src[5] high -> VECTOR=32'h8000_0004; drop src[4] -> VECTOR=32'h8000_0005; drop src[5] -> irq=0 one cycle later, W1C has no effect on bits 4/5.
REQ-032 Edge on src[1] coincident with W1C 8'h02 -> PENDING bit1 remains 1.
REQ-033 src[2] pending, ENABLE=8'h04, CTRL=0 -> irq=0; CTRL=1 -> irq=1 next cycle; assert reset mid-sequence -> irq=0 and all registers 0 immediately.
REQ-034 With IRQ_CTL_SYNC_EN: src[0] rising edge -> pending bit0 set exactly 2 cycles later than without macro, irq 1 cycle after that.

Source files
------------

// File: rtl/irq_controller_if.sv
// CPU-side register bus for the interrupt controller.
// The master drives select/addr/strobes/wdata; the slave returns rdata combinationally.
interface irq_controller_if;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned WE_W   = 4;
    localparam int unsigned DATA_W = 32;

    logic              select;
    logic [ADDR_W-1:0] addr;
    logic [WE_W-1:0]   we;
    logic              rd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        output select, addr, we, rd, wdata,
        input  rdata
    );

    modport slave (
        input  select, addr, we, rd, wdata,
        output rdata
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: per-source level/edge pending, enable mask, priority vector, global enable.
// Optional macro IRQ_CTL_SYNC_EN adds a 2-flop synchronizer on every source line.
module irq_controller #(
    parameter int unsigned NSRC      = 8,
    parameter logic [7:0]  EDGE_MASK = 8'h00
) (
    input  logic              input_clk,
    input  logic              reset,
    irq_controller_if.slave   bus,
    input  logic [NSRC-1:0]   src,
    output logic              irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;

    localparam logic [1:0] ADDR_PEND   = 2'd0;
    localparam logic [1:0] ADDR_ENABLE = 2'd1;
    localparam logic [1:0] ADDR_VECTOR = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [NSRC-1:0] EDGE_BITS  = EDGE_MASK[NSRC-1:0];
    localparam logic [NSRC-1:0] LEVEL_BITS = ~EDGE_BITS;

    logic [NSRC-1:0]  w_src_s;
    logic [NSRC-1:0]  r_src_d;
    logic [NSRC-1:0]  r_pend_edge;
    logic [NSRC-1:0]  r_enable;
    logic             r_ctrl;
    logic             r_irq;

    logic             w_wr;
    logic [NSRC-1:0]  w_clr;
    logic [NSRC-1:0]  w_rise;
    logic [NSRC-1:0]  w_pending;
    logic [NSRC-1:0]  w_active;
    logic [IDX_W-1:0] w_vec_idx;
    logic             w_any;

`ifdef IRQ_CTL_SYNC_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    // Two-stage synchronizer for sources from a foreign clock domain.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_s = r_sync2;
`else
    assign w_src_s = src;
`endif

    assign w_wr   = bus.select & bus.we[0];
    assign w_clr  = (w_wr && (bus.addr == ADDR_PEND)) ? bus.wdata[NSRC-1:0] : '0;
    assign w_rise = w_src_s & ~r_src_d & EDGE_BITS;

    // Level bits mirror the sampled line; edge bits come from the latch.
    assign w_pending = (r_pend_edge & EDGE_BITS) | (w_src_s & LEVEL_BITS);
    assign w_active  = w_pending & r_enable;
    assign w_any     = |w_active;

    // A fresh edge in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_src_d     <= '0;
            r_pend_edge <= '0;
        end else begin
            r_src_d     <= w_src_s;
            r_pend_edge <= ((r_pend_edge & ~w_clr) | w_rise) & EDGE_BITS;
        end
    end

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_enable <= '0;
            r_ctrl   <= 1'b0;
        end else if (w_wr) begin
            if (bus.addr == ADDR_ENABLE) begin
                r_enable <= bus.wdata[NSRC-1:0];
            end
            if (bus.addr == ADDR_CTRL) begin
                r_ctrl <= bus.wdata[0];
            end
        end
    end

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl & w_any;
        end
    end

    assign irq = r_irq;

    // Lowest-numbered active source wins; scan downward so the last hit is the lowest.
    always_comb begin
        w_vec_idx = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.select) begin
            case (bus.addr)
                ADDR_PEND:   bus.rdata = DATA_W'(w_pending);
                ADDR_ENABLE: bus.rdata = DATA_W'(r_enable);
                ADDR_VECTOR: bus.rdata = {w_any, 28'b0, w_vec_idx};
                ADDR_CTRL:   bus.rdata = {31'b0, r_ctrl};
                default:     bus.rdata = '0;
            endcase
        end
    end

    // Read strobe and upper strobes/data bits have no function in this block.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.rd, bus.we[3:1], bus.wdata};

endmodule
